// File: rtl/uart_reg_pkg.sv
// Shared constants, state encoding and timeout sizing helpers for the UART
// register responder.
package uart_reg_pkg;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_NAK = 8'h3F;

    // Cycles WAIT_HI tolerates without seeing the transmitter go busy.
    localparam logic [1:0] TX_HI_LAST = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        SEND,
        WAIT_HI,
        WAIT_LO
    } state_t;

    typedef enum logic {
        OPK_WR,
        OPK_RD
    } op_t;

    // Inter-byte timeout in clock cycles; 64-bit math because
    // TIMEOUT_BYTES*10*CLK_FREQ easily exceeds 32 bits.
    function automatic int calc_to_cycles(input longint clk_freq,
                                          input longint baud_rate,
                                          input longint timeout_bytes);
        longint c;
        c = (timeout_bytes * 64'd10 * clk_freq) / baud_rate;
        if (c < 64'd1) begin
            c = 64'd1;
        end
        return int'(c);
    endfunction

    // Bits needed to hold any value in 0..cycles.
    function automatic int to_width(input int cycles);
        int w;
        w = 1;
        while ((64'd1 << w) < (longint'(cycles) + 64'd1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Loadable down-counter measuring silence between bytes of a command frame.
module uart_byte_timer
    import uart_reg_pkg::*;
#(
    parameter int TO_CYCLES = 69444
) (
    input  logic clk,
    input  logic rst_,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = to_width(TO_CYCLES);
    localparam logic [CW-1:0] LOAD_VAL = CW'(TO_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    // Loading TO_CYCLES-1 makes expiry land on the TO_CYCLES-th running cycle.
    always_ff @(posedge clk) begin
        if (rst_) begin
            r_cnt <= LOAD_VAL;
        end else if (clear) begin
            r_cnt <= LOAD_VAL;
        end else if (run && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign expired = run && !clear && (r_cnt == '0);

endmodule

// File: rtl/uart_reg_responder.sv
// Command-frame decoder and 8-bit register file behind a byte-wide UART;
// answers each frame with exactly one response byte.
module uart_reg_responder
    import uart_reg_pkg::*;
#(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int BAUD_RATE     = 115200,
    parameter int NUM_REGS      = 16,
    parameter int TIMEOUT_BYTES = 16
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  rx_error,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    output logic [NUM_REGS*8-1:0] reg_out,
    output logic                  cmd_err,
    output logic                  busy
);

    localparam int TO_CYCLES = calc_to_cycles(longint'(CLK_FREQ), longint'(BAUD_RATE),
                                              longint'(TIMEOUT_BYTES));
    localparam int AW = $clog2(NUM_REGS);
    localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

    state_t                r_state, w_state_next;
    op_t                   r_op, w_op_next;
    logic [AW-1:0]         r_addr, w_addr_next;
    logic [7:0]            r_tx_data, w_tx_data_next;
    logic                  r_cmd_err, w_cmd_err_next;
    logic [1:0]            r_wait_cnt, w_wait_next;
    logic                  w_wr_en;
    logic                  w_tx_start;
    logic                  w_in_frame;
    logic                  w_timer_clear;
    logic                  w_expired;
    logic                  w_addr_ok;
    logic [AW-1:0]         w_idx;
    logic [7:0]            w_rd_byte;
    logic [NUM_REGS*8-1:0] w_reg_flat;

    assign w_in_frame    = (r_state == GET_ADDR) || (r_state == GET_DATA);
    assign w_timer_clear = rx_valid || !w_in_frame;
    assign w_addr_ok     = ({1'b0, rx_data} < NUM_REGS_W);
    assign w_idx         = rx_data[AW-1:0];

    uart_byte_timer #(
        .TO_CYCLES(TO_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_   (rst_),
        .clear  (w_timer_clear),
        .run    (w_in_frame),
        .expired(w_expired)
    );

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic [7:0] r_val;

        always_ff @(posedge clk) begin
            if (rst_) begin
                r_val <= '0;
            end else if (w_wr_en && (r_addr == AW'(gi))) begin
                r_val <= rx_data;
            end
        end

        assign w_reg_flat[gi*8 +: 8] = r_val;
    end

    // Read data comes straight from the address byte so the response is
    // ready in the cycle right after it arrives.
    always_comb begin
        w_rd_byte = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_idx == AW'(i)) begin
                w_rd_byte = w_reg_flat[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_state    <= IDLE;
            r_op       <= OPK_WR;
            r_addr     <= '0;
            r_tx_data  <= '0;
            r_cmd_err  <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_op       <= w_op_next;
            r_addr     <= w_addr_next;
            r_tx_data  <= w_tx_data_next;
            r_cmd_err  <= w_cmd_err_next;
            r_wait_cnt <= w_wait_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_op_next      = r_op;
        w_addr_next    = r_addr;
        w_tx_data_next = r_tx_data;
        w_cmd_err_next = 1'b0;
        w_wait_next    = r_wait_cnt;
        w_wr_en        = 1'b0;
        w_tx_start     = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == OP_WR) begin
                        w_op_next    = OPK_WR;
                        w_state_next = GET_ADDR;
                    end else if (rx_data == OP_RD) begin
                        w_op_next    = OPK_RD;
                        w_state_next = GET_ADDR;
                    end else begin
                        w_tx_data_next = RSP_NAK;
                        w_state_next   = SEND;
                    end
                end
            end

            GET_ADDR: begin
                // A framing error outranks a byte in the same cycle; a byte
                // outranks a timeout expiring in the same cycle.
                if (rx_error) begin
                    w_cmd_err_next = 1'b1;
                    w_state_next   = IDLE;
                end else if (rx_valid) begin
                    w_addr_next = w_idx;
                    if (!w_addr_ok) begin
                        w_tx_data_next = RSP_NAK;
                        w_state_next   = SEND;
                    end else if (r_op == OPK_RD) begin
                        w_tx_data_next = w_rd_byte;
                        w_state_next   = SEND;
                    end else begin
                        w_state_next = GET_DATA;
                    end
                end else if (w_expired) begin
                    w_cmd_err_next = 1'b1;
                    w_state_next   = IDLE;
                end
            end

            GET_DATA: begin
                if (rx_error) begin
                    w_cmd_err_next = 1'b1;
                    w_state_next   = IDLE;
                end else if (rx_valid) begin
                    w_wr_en        = 1'b1;
                    w_tx_data_next = RSP_ACK;
                    w_state_next   = SEND;
                end else if (w_expired) begin
                    w_cmd_err_next = 1'b1;
                    w_state_next   = IDLE;
                end
            end

            SEND: begin
                w_cmd_err_next = rx_valid;
                if (!tx_busy) begin
                    w_tx_start   = 1'b1;
                    w_wait_next  = '0;
                    w_state_next = WAIT_HI;
                end
            end

            WAIT_HI: begin
                w_cmd_err_next = rx_valid;
                if (tx_busy) begin
                    w_state_next = WAIT_LO;
                end else if (r_wait_cnt == TX_HI_LAST) begin
                    w_state_next = IDLE;
                end else begin
                    w_wait_next = r_wait_cnt + 1'b1;
                end
            end

            WAIT_LO: begin
                w_cmd_err_next = rx_valid;
                if (!tx_busy) begin
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign tx_start = w_tx_start;
    assign tx_data  = r_tx_data;
    assign cmd_err  = r_cmd_err;
    assign busy     = (r_state != IDLE);
    assign reg_out  = w_reg_flat;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Self-checking bench: fixed frame table, corner sequences, and random frames
// scored against a frame-level register model.
module tb_uart_reg_responder;

    localparam int NREG = 16;
    localparam int TO   = 400;   // 4 chars * 10 bits * 1_152_000 / 115200

    logic            clk = 1'b0;
    logic            rst_ = 1'b1;
    logic [7:0]      rx_data = '0;
    logic            rx_valid = 1'b0;
    logic            rx_error = 1'b0;
    logic            tx_busy;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic [NREG*8-1:0] reg_out;
    logic            cmd_err;
    logic            busy;

    uart_reg_responder #(
        .CLK_FREQ     (1_152_000),
        .BAUD_RATE    (115200),
        .NUM_REGS     (NREG),
        .TIMEOUT_BYTES(4)
    ) dut (
        .clk     (clk),
        .rst_    (rst_),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_error(rx_error),
        .tx_busy (tx_busy),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .reg_out (reg_out),
        .cmd_err (cmd_err),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] mdl [NREG];

    // Transmitter emulation: busy for tx_len cycles after each tx_start,
    // or held busy while hold_busy is set.
    int tx_len = 3;
    bit hold_busy = 1'b0;
    initial begin
        int left;
        bit saw;
        left = 0;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            saw = tx_start;
            @(posedge clk);
            #1;
            if (saw) left = tx_len;
            else if (left > 0) left = left - 1;
            tx_busy = hold_busy || (left > 0);
        end
    end

    // Response / error monitor.
    int rsp_count = 0;
    int err_count = 0;
    int stab_err = 0;
    logic [7:0] last_rsp = '0;
    bit in_rsp = 1'b0;
    always @(negedge clk) begin
        if (tx_start) begin
            rsp_count <= rsp_count + 1;
            last_rsp  <= tx_data;
            in_rsp    <= 1'b1;
        end else if (in_rsp && !busy) begin
            in_rsp <= 1'b0;
        end else if (in_rsp && (tx_data !== last_rsp)) begin
            stab_err <= stab_err + 1;
        end
        if (cmd_err) err_count <= err_count + 1;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int frame_len(input logic [7:0] b0, input logic [7:0] b1);
        if (b0 == 8'h57) return (int'(b1) >= NREG) ? 2 : 3;
        if (b0 == 8'h52) return 2;
        return 1;
    endfunction

    // Frame-level model: returns the response byte, applies writes.
    function automatic logic [7:0] model_frame(input logic [7:0] b0, input logic [7:0] b1,
                                               input logic [7:0] b2);
        if (b0 == 8'h57) begin
            if (int'(b1) >= NREG) return 8'h3F;
            mdl[b1[3:0]] = b2;
            return 8'h4B;
        end
        if (b0 == 8'h52) begin
            if (int'(b1) >= NREG) return 8'h3F;
            return mdl[b1[3:0]];
        end
        return 8'h3F;
    endfunction

    function automatic logic [127:0] exp_flat();
        logic [127:0] f;
        f = '0;
        for (int i = 0; i < NREG; i++) f[i*8 +: 8] = mdl[i];
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1 rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
        rx_data = '0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, " idle"}, 128'(ok), 128'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_frame(input string name, input int n, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2, input int gap,
                             input logic [7:0] exp_rsp);
        int r0, e0;
        r0 = rsp_count;
        e0 = err_count;
        send_byte(b0);
        if (n > 1) begin
            repeat (gap) @(posedge clk);
            send_byte(b1);
        end
        if (n > 2) begin
            repeat (gap) @(posedge clk);
            send_byte(b2);
        end
        @(negedge clk);
        check({name, " latency"}, 128'(tx_start), 128'd1);
        wait_idle(name);
        check({name, " rsp_cnt"}, 128'(rsp_count - r0), 128'd1);
        check({name, " rsp"}, 128'(last_rsp), 128'(exp_rsp));
        check({name, " err_cnt"}, 128'(err_count - e0), 128'd0);
        check({name, " regs"}, 128'(reg_out), exp_flat());
        $display("frame %s n=%0d %h %h %h rsp=%h exp=%h", name, n, b0, b1, b2, last_rsp, exp_rsp);
    endtask

    typedef struct {
        int         n;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] rsp;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int r0, e0, starts;
        logic [7:0] b0, b1, b2, ex;

        tbl[0] = '{3, 8'h57, 8'h03, 8'hA5, 8'h4B};
        tbl[1] = '{2, 8'h52, 8'h03, 8'h00, 8'hA5};
        tbl[2] = '{1, 8'h41, 8'h00, 8'h00, 8'h3F};
        tbl[3] = '{2, 8'h57, 8'h10, 8'h00, 8'h3F};
        tbl[4] = '{2, 8'h52, 8'h10, 8'h00, 8'h3F};
        tbl[5] = '{3, 8'h57, 8'h0F, 8'hFF, 8'h4B};
        tbl[6] = '{2, 8'h52, 8'h0F, 8'h00, 8'hFF};
        tbl[7] = '{2, 8'h52, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < NREG; i++) mdl[i] = '0;

        repeat (3) @(posedge clk);
        #1 rst_ = 1'b0;
        @(negedge clk);
        check("rst tx_start", 128'(tx_start), 128'd0);
        check("rst tx_data", 128'(tx_data), 128'd0);
        check("rst cmd_err", 128'(cmd_err), 128'd0);
        check("rst busy", 128'(busy), 128'd0);
        check("rst regs", 128'(reg_out), 128'd0);

        for (int i = 0; i < 8; i++) begin
            void'(model_frame(tbl[i].b0, tbl[i].b1, tbl[i].b2));
            run_frame($sformatf("tbl%0d", i), tbl[i].n, tbl[i].b0, tbl[i].b1, tbl[i].b2,
                      i % 3, tbl[i].rsp);
        end
        check("wr reg3", 128'(reg_out[31:24]), 128'hA5);

        // Timeout after the address byte of a write.
        r0 = rsp_count;
        e0 = err_count;
        send_byte(8'h57);
        send_byte(8'h02);
        repeat (TO - 3) @(negedge clk);
        check("to early busy", 128'(busy), 128'd1);
        check("to early err", 128'(err_count - e0), 128'd0);
        wait_idle("to");
        check("to err", 128'(err_count - e0), 128'd1);
        check("to rsp", 128'(rsp_count - r0), 128'd0);
        $display("timeout frame err=%0d", err_count - e0);
        run_frame("to read", 2, 8'h52, 8'h02, 8'h00, 0, 8'h00);

        // Long but sub-timeout gaps: each byte must reload the timer.
        ex = model_frame(8'h57, 8'h05, 8'h77);
        run_frame("reload", 3, 8'h57, 8'h05, 8'h77, TO - 20, ex);

        // Framing error after the opcode.
        r0 = rsp_count;
        e0 = err_count;
        send_byte(8'h57);
        @(posedge clk);
        #1 rx_error = 1'b1;
        @(posedge clk);
        #1 rx_error = 1'b0;
        wait_idle("ferr");
        check("ferr err", 128'(err_count - e0), 128'd1);
        check("ferr rsp", 128'(rsp_count - r0), 128'd0);
        $display("framing error frame err=%0d", err_count - e0);

        // rx_error together with the data byte: abort, no write.
        r0 = rsp_count;
        e0 = err_count;
        send_byte(8'h57);
        send_byte(8'h06);
        @(posedge clk);
        #1 rx_error = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'h99;
        @(posedge clk);
        #1 rx_error = 1'b0;
        rx_valid = 1'b0;
        rx_data = '0;
        wait_idle("ferr2");
        check("ferr2 err", 128'(err_count - e0), 128'd1);
        check("ferr2 rsp", 128'(rsp_count - r0), 128'd0);
        check("ferr2 regs", 128'(reg_out), exp_flat());
        $display("error+valid frame err=%0d", err_count - e0);
        run_frame("ferr2 read", 2, 8'h52, 8'h06, 8'h00, 1, model_frame(8'h52, 8'h06, 8'h00));

        // Transmitter held busy during the final byte, then a stray byte in WAIT_LO.
        @(negedge clk);
        hold_busy = 1'b1;
        tx_len = 6;
        repeat (2) @(negedge clk);
        r0 = rsp_count;
        e0 = err_count;
        send_byte(8'h52);
        send_byte(8'h03);
        starts = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (tx_start) starts++;
        end
        check("hs held start", 128'(starts), 128'd0);
        check("hs held busy", 128'(busy), 128'd1);
        check("hs held data", 128'(tx_data), 128'hA5);
        hold_busy = 1'b0;
        @(negedge clk);
        check("hs start", 128'(tx_start), 128'd1);
        check("hs data", 128'(tx_data), 128'hA5);
        repeat (2) @(negedge clk);
        send_byte(8'h52);
        wait_idle("hs");
        check("hs rsp_cnt", 128'(rsp_count - r0), 128'd1);
        check("hs err", 128'(err_count - e0), 128'd1);
        check("hs rsp", 128'(last_rsp), 128'hA5);
        $display("handshake frame rsp=%h err=%0d", last_rsp, err_count - e0);

        // Random frames against the model.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: begin
                    b0 = 8'h57;
                    b1 = 8'($urandom_range(0, 19));
                    b2 = 8'($urandom);
                end
                1: begin
                    b0 = 8'h52;
                    b1 = 8'($urandom_range(0, 19));
                    b2 = '0;
                end
                default: begin
                    do b0 = 8'($urandom); while (b0 == 8'h57 || b0 == 8'h52);
                    b1 = '0;
                    b2 = '0;
                end
            endcase
            tx_len = $urandom_range(0, 5);
            ex = model_frame(b0, b1, b2);
            run_frame($sformatf("rnd%0d", i), frame_len(b0, b1), b0, b1, b2,
                      $urandom_range(0, 3), ex);
        end

        // Reset in the middle of a write frame.
        tx_len = 3;
        r0 = rsp_count;
        send_byte(8'h57);
        send_byte(8'h01);
        @(posedge clk);
        #1 rst_ = 1'b1;
        @(posedge clk);
        #1 rst_ = 1'b0;
        for (int i = 0; i < NREG; i++) mdl[i] = '0;
        @(negedge clk);
        check("mrst tx_start", 128'(tx_start), 128'd0);
        check("mrst tx_data", 128'(tx_data), 128'd0);
        check("mrst cmd_err", 128'(cmd_err), 128'd0);
        check("mrst busy", 128'(busy), 128'd0);
        check("mrst regs", 128'(reg_out), 128'd0);
        repeat (2) @(negedge clk);
        check("mrst rsp", 128'(rsp_count - r0), 128'd0);
        $display("reset mid-frame busy=%0d", busy);
        run_frame("mrst read", 2, 8'h52, 8'h01, 8'h00, 0, 8'h00);

        check("tx_data stable", 128'(stab_err), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
